// File: rtl/ara_pkg.sv
// Shared types and helpers for the fixed-point rounding sequencer.
// Holds the operand/strobe types, the op and element-width encodings,
// the sequencer FSM states, and the per-beat element-count and tail-mask helpers.
package ara_pkg;

  typedef logic [63:0] elen_t;
  typedef logic [7:0]  strb_t;

  // Rounding mode (vxrm CSR encoding).
  typedef logic [1:0] vxrm_t;
  localparam vxrm_t VXRM_RNU = 2'b00;  // round-to-nearest-up
  localparam vxrm_t VXRM_RNE = 2'b01;  // round-to-nearest-even
  localparam vxrm_t VXRM_RDN = 2'b10;  // round-down (truncate)
  localparam vxrm_t VXRM_ROD = 2'b11;  // round-to-odd

  typedef enum logic [2:0] {
    VADD    = 3'd0,
    VSSRA   = 3'd1,
    VSSRL   = 3'd2,
    VNCLIP  = 3'd3,
    VNCLIPU = 3'd4
  } ara_op_e;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rc_state_e;

  // Elements carried by one 64-bit beat.
  function automatic logic [3:0] epb_of(input vew_e vew);
    return 4'd8 >> vew;
  endfunction

  // One strobe bit per element slot: set below both the tail count and epb.
  function automatic strb_t tail_mask(input logic [3:0] tail, input vew_e vew);
    strb_t m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < int'(tail)) && (i < int'(epb_of(vew)));
    end
    return m;
  endfunction

  function automatic logic is_fixp_op(input ara_op_e op);
    return op inside {VSSRA, VSSRL, VNCLIP, VNCLIPU};
  endfunction

  // Narrowing clips take a shift amount twice as wide as the element.
  function automatic logic is_narrow_op(input ara_op_e op);
    return op inside {VNCLIP, VNCLIPU};
  endfunction

endpackage

// File: rtl/fixed_p_round_ctrl_rounding.sv
// Combinational fixed-point rounding unit (fixed_p_rounding).
// For each element of a beat it computes the rounding increment that the
// downstream shifter adds after shifting opb right by the amount in opa.
module fixed_p_rounding
  import ara_pkg::*;
(
  input  logic    valid_i,
  input  ara_op_e op_i,
  input  vew_e    vew_i,
  input  vxrm_t   vxrm_i,
  input  elen_t   opa_i,
  input  elen_t   opb_i,
  output strb_t   r_o
);

  // Extract element e of a beat, zero-extended to 64 bits.
  function automatic elen_t elem_of(input elen_t data, input int e, input vew_e vew);
    int    sew;
    elen_t mask;
    sew  = 8 << vew;
    mask = (sew == 64) ? '1 : ((elen_t'(1) << sew) - elen_t'(1));
    return (data >> (e * sew)) & mask;
  endfunction

  // Increment for value v shifted right by d under rounding mode m.
  function automatic logic round_bit(input elen_t v, input logic [6:0] d, input vxrm_t m);
    elen_t sh_half;
    elen_t sh_lsb;
    elen_t low_mask;
    logic  half;
    logic  lsb;
    logic  sticky;
    logic  r;
    sh_half  = v >> (d - 7'd1);
    sh_lsb   = v >> d;
    low_mask = (elen_t'(1) << (d - 7'd1)) - elen_t'(1);
    half     = sh_half[0];
    lsb      = sh_lsb[0];
    sticky   = |(v & low_mask);
    case (m)
      VXRM_RNU: r = half;
      VXRM_RNE: r = half & (sticky | lsb);
      VXRM_RDN: r = 1'b0;
      VXRM_ROD: r = ~lsb & (half | sticky);
      default:  r = 1'b0;
    endcase
    // A zero shift discards nothing, so there is never an increment.
    return (d == 7'd0) ? 1'b0 : r;
  endfunction

  // Per-element increment; empty slots above epb and non-fixed-point ops give 0.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    r_o = '0;
    if (valid_i && is_fixp_op(op_i)) begin
      for (int e = 0; e < 8; e++) begin
        if (e < int'(epb_of(vew_i))) begin
          r_o[e] = round_bit(
            elem_of(opb_i, e, vew_i),
            7'(elem_of(opa_i, e, vew_i) &
               elen_t'(is_narrow_op(op_i) ? (16 << vew_i) - 1 : (8 << vew_i) - 1)),
            vxrm_i);
        end
      end
    end
  end

endmodule

// File: rtl/fixed_p_round_ctrl.sv
// Lane-level sequencer for fixed-point rounding (VSSRA/VSSRL/VNCLIP/VNCLIPU).
// Accepts one command, pops paired 64-bit beats from the shift-amount (A) and
// value (B) queues, and presents each beat with its tail-masked rounding strobe.
// Build option: FIXP_ROUND_CTRL_OUT_REG_EN adds a register after the rounding
// unit (latency N+2, still one beat per cycle); by default the strobe is
// combinational from the issue register (latency N+1).
module fixed_p_round_ctrl
  import ara_pkg::*;
#(
  parameter int unsigned VlWidth   = 16,
  parameter int unsigned DataWidth = $bits(elen_t),
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  ara_op_e              cmd_op_i,
  input  vew_e                 cmd_vew_i,
  input  vxrm_t                cmd_vxrm_i,
  input  logic [VlWidth-1:0]   cmd_vl_i,
  input  logic [DataWidth-1:0] opa_i,
  input  logic                 opa_valid_i,
  output logic                 opa_ready_o,
  input  logic [DataWidth-1:0] opb_i,
  input  logic                 opb_valid_i,
  output logic                 opb_ready_o,
  output logic [DataWidth-1:0] res_opa_o,
  output logic [DataWidth-1:0] res_opb_o,
  output logic [StrbWidth-1:0] res_r_o,
  output logic                 res_last_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 done_o
);

  localparam int unsigned VlW1 = VlWidth + 1;

  rc_state_e          state_q, state_d;
  ara_op_e            op_q;
  vew_e               vew_q;
  vxrm_t              vxrm_q;
  logic [3:0]         tail_q;
  logic [VlWidth-1:0] beats_q;
  logic               done_q;

  logic               iss_valid_q;
  logic               iss_last_q;
  elen_t              iss_opa_q, iss_opb_q;

  logic               cmd_accept;
  logic [3:0]         epb_m1;
  logic [1:0]         ew_shift;
  logic [3:0]         tail_d;
  logic [VlWidth-1:0] beats_d;
  logic               stage_free;
  logic               iss_leave;
  logic               pop;
  logic               last_hs;
  strb_t              round_r;
  strb_t              r_masked;

  // Command decode: beats = ceil(vl/epb), tail = elements in the final beat.
  assign cmd_accept = cmd_valid_i & (state_q == ST_IDLE);
  assign epb_m1     = epb_of(cmd_vew_i) - 4'd1;
  assign ew_shift   = 2'd3 - cmd_vew_i;
  assign tail_d     = ((cmd_vl_i[3:0] - 4'd1) & epb_m1) + 4'd1;
  assign beats_d    = VlWidth'(({1'b0, cmd_vl_i} + VlW1'(epb_m1)) >> ew_shift);

  // Both queues are popped together, only while running and the stage can take a beat.
  assign pop         = (state_q == ST_RUN) & opa_valid_i & opb_valid_i & stage_free;
  assign opa_ready_o = pop;
  assign opb_ready_o = pop;
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign done_o      = done_q;
  assign last_hs     = res_valid_o & res_ready_i & res_last_o;

  fixed_p_rounding i_rounding (
    .valid_i (iss_valid_q),
    .op_i    (op_q),
    .vew_i   (vew_q),
    .vxrm_i  (vxrm_q),
    .opa_i   (iss_opa_q),
    .opb_i   (iss_opb_q),
    .r_o     (round_r)
  );

  assign r_masked = round_r & tail_mask(iss_last_q ? tail_q : 4'd8, vew_q);

`ifdef FIXP_ROUND_CTRL_OUT_REG_EN
  logic  s2_valid_q;
  logic  s2_last_q;
  elen_t s2_opa_q, s2_opb_q;
  strb_t s2_r_q;
  logic  s2_free;

  assign s2_free    = ~s2_valid_q | res_ready_i;
  assign iss_leave  = s2_free;
  assign stage_free = ~iss_valid_q | s2_free;

  // Output stage: takes the issue beat and its strobe whenever it is free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_opa_q   <= '0;
      s2_opb_q   <= '0;
      s2_r_q     <= '0;
    end else if (s2_free) begin
      s2_valid_q <= iss_valid_q;
      if (iss_valid_q) begin
        s2_last_q <= iss_last_q;
        s2_opa_q  <= iss_opa_q;
        s2_opb_q  <= iss_opb_q;
        s2_r_q    <= r_masked;
      end
    end
  end

  assign res_valid_o = s2_valid_q;
  assign res_last_o  = s2_last_q;
  assign res_opa_o   = s2_opa_q;
  assign res_opb_o   = s2_opb_q;
  assign res_r_o     = s2_r_q;
`else
  assign iss_leave  = res_ready_i;
  assign stage_free = ~iss_valid_q | res_ready_i;

  assign res_valid_o = iss_valid_q;
  assign res_last_o  = iss_last_q;
  assign res_opa_o   = iss_opa_q;
  assign res_opb_o   = iss_opb_q;
  assign res_r_o     = r_masked;
`endif

  // Next-state logic for the IDLE -> RUN -> DRAIN sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_accept && cmd_vl_i != '0) state_d = ST_RUN;
      ST_RUN:   if (pop && beats_q == VlWidth'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (last_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, latched command fields, beat counter, done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= VADD;
      vew_q   <= EW8;
      vxrm_q  <= VXRM_RNU;
      tail_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (cmd_accept && cmd_vl_i == '0) || last_hs;
      if (cmd_accept) begin
        op_q    <= cmd_op_i;
        vew_q   <= cmd_vew_i;
        vxrm_q  <= cmd_vxrm_i;
        tail_q  <= tail_d;
        beats_q <= beats_d;
      end else if (pop) begin
        beats_q <= beats_q - VlWidth'(1);
      end
    end
  end

  // Issue register: loads on pop, empties when the next stage takes the beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: datapath registers are reset too because their values are visible on the result ports.
    if (rst_i) begin
      iss_valid_q <= 1'b0;
      iss_last_q  <= 1'b0;
      iss_opa_q   <= '0;
      iss_opb_q   <= '0;
    end else if (pop) begin
      iss_valid_q <= 1'b1;
      iss_last_q  <= (beats_q == VlWidth'(1));
      iss_opa_q   <= opa_i;
      iss_opb_q   <= opb_i;
    end else if (iss_leave) begin
      iss_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_p_round_ctrl.sv
// Directed bench for fixed_p_round_ctrl with hand-computed expected strobes.
module tb_fixed_p_round_ctrl;
  import ara_pkg::*;

`ifdef FIXP_ROUND_CTRL_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  ara_op_e     cmd_op_i;
  vew_e        cmd_vew_i;
  vxrm_t       cmd_vxrm_i;
  logic [15:0] cmd_vl_i;
  logic [63:0] opa_i, opb_i;
  logic        opa_valid_i, opa_ready_o;
  logic        opb_valid_i, opb_ready_o;
  logic [63:0] res_opa_o, res_opb_o;
  logic [7:0]  res_r_o;
  logic        res_last_o, res_valid_o, res_ready_i, done_o;

  fixed_p_round_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_vew_i   (cmd_vew_i),
    .cmd_vxrm_i  (cmd_vxrm_i),
    .cmd_vl_i    (cmd_vl_i),
    .opa_i       (opa_i),
    .opa_valid_i (opa_valid_i),
    .opa_ready_o (opa_ready_o),
    .opb_i       (opb_i),
    .opb_valid_i (opb_valid_i),
    .opb_ready_o (opb_ready_o),
    .res_opa_o   (res_opa_o),
    .res_opb_o   (res_opb_o),
    .res_r_o     (res_r_o),
    .res_last_o  (res_last_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  int rdy_split = 0;

  logic [63:0] src_a [8];
  logic [63:0] src_b [8];
  logic [63:0] got_opa [16];
  logic [63:0] got_opb [16];
  logic [7:0]  got_r [16];
  logic        got_last [16];
  int          n_got;
  int          g_pops;
  int          g_lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command and run it to done (or to rst_at pops, then reset).
  task automatic run_cmd(input string name, input ara_op_e op, input vew_e vew,
                         input vxrm_t vxrm, input logic [15:0] vl, input int nsrc,
                         input int stall_at, input int stall_len, input int rst_at);
    int idx = 0;
    int sc = 0;
    int budget = 0;
    int t_acc, t_pop0, t_hs0, t_last_hs, t_done;
    bit seen_done = 0;
    bit rst_hit = 0;
    bit popped;
    t_pop0 = -1; t_hs0 = -1; t_last_hs = -1; t_done = -1;
    n_got = 0;
    g_pops = 0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_vew_i   = vew;
    cmd_vxrm_i  = vxrm;
    cmd_vl_i    = vl;
    @(negedge clk_i);
    check({name, "_cmd_ready"}, cmd_ready_o, 1);
    t_acc = cyc;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    while (!seen_done && !rst_hit && budget < 200) begin
      opa_valid_i = (idx < nsrc);
      opb_valid_i = (idx < nsrc);
      opa_i = (idx < nsrc) ? src_a[idx] : 64'd0;
      opb_i = (idx < nsrc) ? src_b[idx] : 64'd0;
      res_ready_i = !(n_got == stall_at && sc < stall_len);
      @(negedge clk_i);
      popped = opa_valid_i && opa_ready_o;
      if (opa_ready_o !== opb_ready_o) rdy_split++;
      if (popped) begin
        g_pops++;
        if (t_pop0 < 0) t_pop0 = cyc;
      end
      if (!res_ready_i) begin
        sc++;
        check({name, "_bp_nopop"}, opa_ready_o, 0);
        check({name, "_bp_valid"}, res_valid_o, 1);
        check({name, "_bp_hold"}, res_opb_o, src_b[n_got]);
      end
      if (res_valid_o && res_ready_i && n_got < 16) begin
        got_opa[n_got]  = res_opa_o;
        got_opb[n_got]  = res_opb_o;
        got_r[n_got]    = res_r_o;
        got_last[n_got] = res_last_o;
        if (t_hs0 < 0) t_hs0 = cyc;
        if (res_last_o) t_last_hs = cyc;
        n_got++;
      end
      if (done_o) begin
        seen_done = 1;
        t_done = cyc;
      end
      @(posedge clk_i); #1;
      if (popped) idx++;
      if (rst_at >= 0 && g_pops == rst_at) begin
        rst_i = 1'b1;
        rst_hit = 1;
      end
      budget++;
    end
    opa_valid_i = 1'b0;
    opb_valid_i = 1'b0;
    res_ready_i = 1'b1;
    g_lat = t_hs0 - t_pop0;
    if (rst_hit) begin
      @(negedge clk_i);
      check({name, "_rst_cmd_ready"}, cmd_ready_o, 1);
      check({name, "_rst_opa_ready"}, opa_ready_o, 0);
      check({name, "_rst_valid"}, res_valid_o, 0);
      check({name, "_rst_last"}, res_last_o, 0);
      check({name, "_rst_done"}, done_o, 0);
      check({name, "_rst_opa"}, res_opa_o, 0);
      check({name, "_rst_opb"}, res_opb_o, 0);
      check({name, "_rst_r"}, res_r_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
    end else begin
      check({name, "_done_seen"}, seen_done, 1);
      if (vl == 16'd0) check({name, "_done_time"}, t_done, t_acc + 1);
      else             check({name, "_done_time"}, t_done, t_last_hs + 1);
      @(negedge clk_i);
      check({name, "_done_pulse"}, done_o, 0);
      check({name, "_idle_ready"}, cmd_ready_o, 1);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i = VADD;
    cmd_vew_i = EW8;
    cmd_vxrm_i = VXRM_RNU;
    cmd_vl_i = '0;
    opa_i = '0;
    opb_i = '0;
    opa_valid_i = 1'b0;
    opb_valid_i = 1'b0;
    res_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("reset_cmd_ready", cmd_ready_o, 1);
    check("reset_opa_ready", opa_ready_o, 0);
    check("reset_opb_ready", opb_ready_o, 0);
    check("reset_valid", res_valid_o, 0);
    check("reset_last", res_last_o, 0);
    check("reset_done", done_o, 0);
    check("reset_r", res_r_o, 0);
    check("reset_opa", res_opa_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // EW8 VSSRL rnu vl=8: shift 1 of value 1 -> every element rounds up.
    src_a[0] = 64'h0101010101010101;
    src_b[0] = 64'h0101010101010101;
    run_cmd("t1", VSSRL, EW8, VXRM_RNU, 16'd8, 1, -1, 0, -1);
    check("t1_beats", n_got, 1);
    check("t1_pops", g_pops, 1);
    check("t1_r", got_r[0], 8'hFF);
    check("t1_last", got_last[0], 1);
    check("t1_opb", got_opb[0], 64'h0101010101010101);
    check("t1_opa", got_opa[0], 64'h0101010101010101);
    check("t1_latency", g_lat, Lat);

    // Same operands under a non-fixed-point op: beat flows, strobe is 0.
    run_cmd("nofx", VADD, EW8, VXRM_RNU, 16'd8, 1, -1, 0, -1);
    check("nofx_beats", n_got, 1);
    check("nofx_r", got_r[0], 8'h00);
    check("nofx_last", got_last[0], 1);

    // EW16 VSSRA rne vl=10: 3 beats, tail 2. 0x0003>>1 rounds, 0x0001>>1 ties to even.
    for (int i = 0; i < 3; i++) src_a[i] = 64'h0001000100010001;
    src_b[0] = 64'h0003000100030001;
    src_b[1] = 64'h0003000100030001;
    src_b[2] = 64'h0003000300030003;
    run_cmd("t2", VSSRA, EW16, VXRM_RNE, 16'd10, 3, -1, 0, -1);
    check("t2_beats", n_got, 3);
    check("t2_pops", g_pops, 3);
    check("t2_r0", got_r[0], 8'h0A);
    check("t2_r1", got_r[1], 8'h0A);
    check("t2_r2_tail", got_r[2], 8'h03);
    check("t2_last0", got_last[0], 0);
    check("t2_last1", got_last[1], 0);
    check("t2_last2", got_last[2], 1);
    check("t2_opb2", got_opb[2], 64'h0003000300030003);

    // EW8 VSSRL rod vl=3: unmasked strobe 0xF9, tail 3 keeps only bit 0.
    src_a[0] = 64'h0101010101010101;
    src_b[0] = 64'h0101010101020301;
    run_cmd("rod", VSSRL, EW8, VXRM_ROD, 16'd3, 1, -1, 0, -1);
    check("rod_beats", n_got, 1);
    check("rod_r", got_r[0], 8'h01);

    // EW32 VNCLIP rdn vl=4: truncation never increments.
    src_a[0] = 64'h0000000300000003;
    src_a[1] = 64'h0000000300000003;
    src_b[0] = 64'h0000000F0000000F;
    src_b[1] = 64'h000000FF000000FF;
    run_cmd("t3", VNCLIP, EW32, VXRM_RDN, 16'd4, 2, -1, 0, -1);
    check("t3_beats", n_got, 2);
    check("t3_r0", got_r[0], 8'h00);
    check("t3_r1", got_r[1], 8'h00);
    check("t3_last1", got_last[1], 1);

    // vl=0: no pops, done one cycle after accept.
    run_cmd("t4", VSSRL, EW8, VXRM_RNU, 16'd0, 0, -1, 0, -1);
    check("t4_pops", g_pops, 0);
    check("t4_beats", n_got, 0);

    // EW64 rnu vl=4 with 3 stall cycles on the second beat.
    src_a[0] = 64'd1; src_b[0] = 64'h1;
    src_a[1] = 64'd4; src_b[1] = 64'h8;
    src_a[2] = 64'd4; src_b[2] = 64'h7;
    src_a[3] = 64'd0; src_b[3] = 64'hFF;
    run_cmd("t5", VSSRL, EW64, VXRM_RNU, 16'd4, 4, 1, 3, -1);
    check("t5_beats", n_got, 4);
    check("t5_pops", g_pops, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_opb%0d", i), got_opb[i], src_b[i]);
    check("t5_r0", got_r[0], 8'h01);
    check("t5_r1", got_r[1], 8'h01);
    check("t5_r2", got_r[2], 8'h00);
    check("t5_r3", got_r[3], 8'h00);
    check("t5_last3", got_last[3], 1);

    // Reset after 2 of 5 beats, then a clean command.
    for (int i = 0; i < 5; i++) begin
      src_a[i] = 64'd1;
      src_b[i] = 64'd1;
    end
    run_cmd("t6", VSSRA, EW64, VXRM_RNU, 16'd5, 5, -1, 0, 2);
    src_a[0] = 64'h0101010101010101;
    src_b[0] = 64'h0101010101010101;
    run_cmd("t6b", VSSRL, EW8, VXRM_RNU, 16'd8, 1, -1, 0, -1);
    check("t6b_beats", n_got, 1);
    check("t6b_r", got_r[0], 8'hFF);
    check("t6b_last", got_last[0], 1);

    check("ready_pair", rdy_split, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fixed_p_round_ctrl.md
# fixed_p_round_ctrl

Lane-level sequencer for fixed-point rounding (VSSRA, VSSRL, VNCLIP, VNCLIPU). Accepts one instruction command at a time, pops 64-bit operand beats from the shift-amount (A) and value (B) operand queues, and drives the combinational rounding unit. It registers each beat with its per-element rounding-increment strobe toward the lane shifter/narrower and masks tail elements on the last beat. Sits between the lane operand queues and the fixed-point shift datapath in the VALU.

## Interface
Parameters:
- VlWidth, 16, width of per-lane element count
- DataWidth, $bits(elen_t) = 64, beat width (dependent, do not change)
- StrbWidth, DataWidth/8 = 8, round-strobe width (dependent)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i / cmd_ready_o  in/out  1  instruction handshake
- cmd_op_i  in  ara_op_e  operation
- cmd_vew_i  in  vew_e  element width
- cmd_vxrm_i  in  vxrm_t  rounding mode, sampled at command accept
- cmd_vl_i  in  VlWidth  elements for this lane
- opa_i, opa_valid_i / opa_ready_o  in/out  DataWidth/1/1  shift-amount queue
- opb_i, opb_valid_i / opb_ready_o  in/out  DataWidth/1/1  value queue
- res_opa_o, res_opb_o  out  DataWidth  beat passed to shifter
- res_r_o  out  StrbWidth  rounding increment per element, tail-masked
- res_last_o  out  1  final beat of instruction
- res_valid_o / res_ready_i  out/in  1  result handshake
- done_o  out  1  one-cycle instruction-complete pulse

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch op, vew, vxrm and vl.
  - Elements per beat: epb = 8 >> vew (EW8=8, EW16=4, EW32=2, EW64=1).
  - beats = ceil(vl/epb).
  - tail = vl - (beats-1)*epb.
  - If vl=0: pulse done_o next cycle and stay IDLE. Otherwise go to RUN.
- RUN:
  - pop = opa_valid_i & opb_valid_i & stage_free.
  - opa_ready_o = opb_ready_o = pop. The two queues are never popped separately.
  - Each pop loads the issue register and decrements the beat counter.
  - The pop of beat count 1 sets last and moves to DRAIN.
- DRAIN:
  - No pops.
  - On the res handshake with res_last_o=1, go to IDLE and pulse done_o the following cycle.
- Rounding strobe:
  - The rounding unit is fed from the issue register with valid = register occupied.
  - For non-fixed-point ops it returns 0, and the beats still flow.
  - On the last beat, res_r_o bits at index ≥ tail are forced to 0.
  - Bits at index ≥ epb are always 0.
- Any new command is ignored (cmd_ready_o=0) outside IDLE. A new command may be accepted in the same cycle done_o pulses.
- Reset mid-instruction: all state cleared immediately and in-flight beats dropped. The operand queues are not drained by this block.

## Timing
- Reset values:
  - cmd_ready_o=1.
  - opa_ready_o=0, opb_ready_o=0.
  - res_valid_o=0, res_last_o=0, done_o=0.
  - res_opa_o=0, res_opb_o=0, res_r_o=0.
- Latency:
  - A beat popped in cycle N is presented at res_valid_o in cycle N+1 (default).
  - The beat stays presented until res_ready_i.
- Throughput:
  - stage_free = !res_valid_o | res_ready_i, giving 1 beat/cycle under continuous ready.
  - The result stage holds all outputs stable while res_valid_o & !res_ready_i.
- done_o: asserted exactly one cycle, the cycle after the last result handshake (or 1 cycle after accepting vl=0).

## Configuration
- FIXP_ROUND_CTRL_OUT_REG_EN defined:
  - Inserts a second register after the rounding unit, so latency is N+2.
  - The issue stage uses per-stage valid/stall: stage1_free = !stage2_valid | res_ready_i.
  - Full throughput is preserved.
  - DRAIN waits for both stages to empty.
- Undefined: single register stage. The rounding unit output drives res_r_o through the mask combinationally from the issue register.

## Structure
- Put in ara_pkg:
  - The FSM state enum.
  - An epb lookup function (vew_e -> 4-bit count).
  - A tail-mask function (tail, vew -> strb_t).
- One sub-module: the existing fixed_p_rounding unit, instantiated once.
- Counters, FSM and pipeline registers stay in this module.

## Test plan
- EW8, VSSRL, vxrm=00, vl=8, opa=0x0101010101010101, opb=0x0101010101010101 -> one beat, res_r_o=0xFF, res_last_o=1, done_o one cycle after handshake.
- EW16, VSSRA, vxrm=01, vl=10 -> 3 beats; last beat res_r_o bits [3:2] forced 0; done_o after 3rd handshake.
- vxrm=10 (rdn), EW32, vl=4 -> 2 beats, res_r_o=0 on both.
- vl=0 command -> no operand pops, done_o pulses 1 cycle after accept, FSM back in IDLE.
- Backpressure: res_ready_i low 3 cycles mid-stream with both queues valid -> no pops, outputs stable, no beat lost or duplicated.
- rst_i asserted in RUN after 2 of 5 beats -> next edge all outputs at reset values, cmd_ready_o=1; new command runs cleanly.
